// File: rtl/lenet_layer_scheduler.sv
// Sequences the four LeNet layer engines (conv1..conv3, FC), guards each layer with a
// timeout, then scans the ten captured FC scores for the winning class.
module lenet_layer_scheduler #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic [3:0]            layer_start,
  input  logic [3:0]            layer_done,
  output logic [1:0]            cfg_layer,
  input  logic [10*DATA_W-1:0]  score_in,
  output logic                  done,
  output logic [3:0]            class_id,
  output logic [DATA_W-1:0]     class_score,
  output logic                  error
);

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StArgmax, StDone} state_e;

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic [1:0]                 r_k;
  logic [15:0]                r_cnt;
  logic [3:0]                 r_idx;
  logic signed [DATA_W-1:0]   r_sc [10];
  logic signed [DATA_W-1:0]   r_best;
  logic [3:0]                 r_best_idx;
  logic [3:0]                 r_class_id;
  logic signed [DATA_W-1:0]   r_class_score;
  logic                       r_error;
  logic signed [DATA_W-1:0]   w_cur;
  logic                       w_take;
  logic                       w_done_k;

  assign w_done_k = layer_done[r_k];
  assign w_cur    = r_sc[r_idx];
  // Strictly-greater replacement keeps the lowest index on ties.
  assign w_take   = (r_idx == 4'd0) || (w_cur > r_best);

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_nxt = StLaunch;
      StLaunch: w_state_nxt = StWait;
      StWait: begin
        if (w_done_k)              w_state_nxt = (r_k == 2'd3) ? StArgmax : StLaunch;
        else if (r_cnt == LP_LAST) w_state_nxt = StDone;
      end
      StArgmax: if (r_idx == 4'd9) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k           <= 2'd0;
      r_cnt         <= 16'd0;
      r_idx         <= 4'd0;
      r_best        <= '0;
      r_best_idx    <= 4'd0;
      r_class_id    <= 4'd0;
      r_class_score <= '0;
      r_error       <= 1'b0;
      for (int i = 0; i < 10; i++) r_sc[i] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_k     <= 2'd0;
            r_error <= 1'b0;
          end
        end
        StLaunch: r_cnt <= 16'd0;
        StWait: begin
          if (w_done_k) begin
            if (r_k == 2'd3) begin
              for (int i = 0; i < 10; i++) r_sc[i] <= score_in[i*DATA_W +: DATA_W];
              r_idx <= 4'd0;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end else if (r_cnt == LP_LAST) begin
            r_error       <= 1'b1;
            r_class_id    <= 4'hF;
            r_class_score <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StArgmax: begin
          if (w_take) begin
            r_best     <= w_cur;
            r_best_idx <= r_idx;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd9) begin
            r_class_id    <= w_take ? r_idx : r_best_idx;
            r_class_score <= w_take ? w_cur : r_best;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != StIdle);
    layer_start = 4'b0000;
    cfg_layer   = 2'd0;
    done        = (r_state == StDone);
    unique case (r_state)
      StLaunch: begin
        layer_start = 4'b0001 << r_k;
        cfg_layer   = r_k;
      end
      StWait:           cfg_layer = r_k;
      StArgmax, StDone: cfg_layer = 2'd3;
      default:          cfg_layer = 2'd0;
    endcase
  end

  assign class_id    = r_class_id;
  assign class_score = r_class_score;
  assign error       = r_error;

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Plans a whole stimulus timeline up front, derives the expected per-cycle outputs from the
// scheduling rules, then plays the stimulus back and compares every cycle.
module tb_lenet_layer_scheduler;

  localparam int DW  = 4;
  localparam int TMO = 16;
  localparam int N   = 4000;
  localparam int NONE = 32'h7fffffff;

  logic            clk;
  logic            reset;
  logic            start;
  logic            busy;
  logic [3:0]      layer_start;
  logic [3:0]      layer_done;
  logic [1:0]      cfg_layer;
  logic [10*DW-1:0] score_in;
  logic            done;
  logic [3:0]      class_id;
  logic [DW-1:0]   class_score;
  logic            error;

  lenet_layer_scheduler #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .cfg_layer   (cfg_layer),
    .score_in    (score_in),
    .done        (done),
    .class_id    (class_id),
    .class_score (class_score),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus timeline
  bit          drv_start [N];
  bit          drv_reset [N];
  logic [3:0]  drv_done  [N];
  logic [3:0]  drv_mask  [N];
  logic [39:0] drv_score [N];
  // Expected outputs per cycle
  bit          e_busy [N];
  logic [3:0]  e_ls   [N];
  logic [1:0]  e_cfg  [N];
  bit          e_done [N];
  bit          e_err  [N];
  bit          e_chk  [N];
  logic [3:0]  e_cls  [N];
  logic [3:0]  e_scr  [N];

  int h_cls, h_scr, cur, rst_at, n_end, cyc;
  bit h_err, running;
  int n_chk, n_fail;

  function automatic void argmax(input logic [39:0] v, output int idx, output int val);
    logic signed [3:0] t;
    t = v[3:0];
    idx = 0;
    val = t;
    for (int i = 1; i < 10; i++) begin
      t = v[i*4 +: 4];
      if (int'(t) > val) begin
        idx = i;
        val = t;
      end
    end
  endfunction

  function automatic logic [39:0] mkvec(input int s [10]);
    logic [39:0] v;
    for (int i = 0; i < 10; i++) v[i*4 +: 4] = 4'(s[i]);
    return v;
  endfunction

  task automatic set_c(input int c, input bit b, input logic [3:0] ls, input logic [1:0] cf,
                       input bit dn);
    if (c > rst_at) return;
    e_busy[c] = b;
    e_ls[c]   = ls;
    e_cfg[c]  = cf;
    e_done[c] = dn;
    e_err[c]  = h_err;
    e_chk[c]  = !b || dn;
    e_cls[c]  = 4'(h_cls);
    e_scr[c]  = 4'(h_scr);
  endtask

  task automatic fill_idle(input int a, input int b);
    for (int c = a; c <= b; c++) set_c(c, 1'b0, 4'b0, 2'd0, 1'b0);
  endtask

  // dly[k] = cycles from layer_start[k] to layer_done[k]; 0 means the engine never answers.
  task automatic go(input int gap, input int d0, input int d1, input int d2, input int d3,
                    input bit fix, input logic [39:0] vec, input int rk, input int roff);
    int dly [4];
    int s, l, d, idx, val;
    bit tmo;
    dly = '{d0, d1, d2, d3};
    s = cur + gap;
    rst_at = NONE;
    fill_idle(cur, s - 1);
    set_c(s, 1'b0, 4'b0, 2'd0, 1'b0);
    drv_start[s] = 1'b1;
    h_err = 1'b0;
    l = s + 1;
    d = l;
    tmo = 1'b0;
    for (int k = 0; k < 4 && !tmo; k++) begin
      if (k == rk) rst_at = l + roff;
      for (int c = l; c <= l + TMO; c++) drv_mask[c][k] = 1'b1;
      if (dly[k] > 0) drv_done[l + dly[k]][k] = 1'b1;
      if (dly[k] >= 1 && dly[k] <= TMO) begin
        for (int c = l; c <= l + dly[k]; c++)
          set_c(c, 1'b1, (c == l) ? 4'(1 << k) : 4'b0, 2'(k), 1'b0);
        d = l + dly[k];
        l = d + 1;
      end else begin
        for (int c = l; c <= l + TMO; c++)
          set_c(c, 1'b1, (c == l) ? 4'(1 << k) : 4'b0, 2'(k), 1'b0);
        h_err = 1'b1;
        h_cls = 15;
        h_scr = 0;
        set_c(l + TMO + 1, 1'b1, 4'b0, 2'd3, 1'b1);
        cur = l + TMO + 2;
        tmo = 1'b1;
      end
    end
    if (!tmo) begin
      if (fix) drv_score[d] = vec;
      argmax(drv_score[d], idx, val);
      for (int c = d + 1; c <= d + 10; c++) set_c(c, 1'b1, 4'b0, 2'd3, 1'b0);
      h_err = 1'b0;
      h_cls = idx;
      h_scr = val;
      set_c(d + 11, 1'b1, 4'b0, 2'd3, 1'b1);
      cur = d + 12;
    end
    if (rst_at != NONE) begin
      drv_reset[rst_at] = 1'b1;
      h_err = 1'b0;
      h_cls = 0;
      h_scr = 0;
      cur = rst_at + 1;
    end
    rst_at = NONE;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (running && cyc >= 1) begin
      chk("busy", int'(busy), int'(e_busy[cyc]));
      chk("layer_start", int'(layer_start), int'(e_ls[cyc]));
      chk("cfg_layer", int'(cfg_layer), int'(e_cfg[cyc]));
      chk("done", int'(done), int'(e_done[cyc]));
      chk("error", int'(error), int'(e_err[cyc]));
      if (e_chk[cyc]) begin
        chk("class_id", int'(class_id), int'(e_cls[cyc]));
        chk("class_score", int'(class_score), int'(e_scr[cyc]));
      end
      // Hand-derived timeline of the nominal run (start at cycle 5, engines answer after 5).
      case (cyc)
        6:  chk("lit_ls0", int'(layer_start), 1);
        12: chk("lit_ls1", int'(layer_start), 2);
        18: chk("lit_ls2", int'(layer_start), 4);
        24: chk("lit_ls3", int'(layer_start), 8);
        40: begin
          chk("lit_done", int'(done), 1);
          chk("lit_class_id", int'(class_id), 3);
          chk("lit_class_score", int'(class_score), 7);
        end
        default: ;
      endcase
    end
  end

  task automatic apply(input int c);
    reset      = drv_reset[c];
    start      = drv_start[c];
    layer_done = drv_done[c];
    score_in   = drv_score[c];
  endtask

  initial begin
    int v_nom [10];
    int v_neg [10];
    int v_eq [10];
    int s_hold;
    n_chk = 0;
    n_fail = 0;
    running = 1'b0;
    cyc = 0;
    for (int c = 0; c < N; c++) begin
      drv_start[c] = 1'b0;
      drv_reset[c] = 1'b0;
      drv_done[c]  = 4'b0;
      drv_mask[c]  = 4'b0;
      drv_score[c] = 40'({$urandom, $urandom});
      e_chk[c]     = 1'b0;
    end
    v_nom = '{1, -2, 3, 7, 0, -8, 7, 2, -1, 4};
    v_neg = '{-8, -8, -8, -8, -8, -8, -1, -8, -8, -8};
    v_eq  = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    drv_reset[0] = 1'b1;
    drv_reset[1] = 1'b1;
    h_err = 1'b0;
    h_cls = 0;
    h_scr = 0;
    rst_at = NONE;
    cur = 1;

    go(4, 5, 5, 5, 5, 1'b1, mkvec(v_nom), -1, 0);
    go(3, 3, 7, 2, 9, 1'b1, mkvec(v_neg), -1, 0);
    go(2, 1, 1, 1, 1, 1'b1, mkvec(v_eq), -1, 0);
    go(2, 3, 0, 5, 5, 1'b0, 40'd0, -1, 0);
    go(1, TMO, 1, TMO, TMO, 1'b0, 40'd0, -1, 0);
    go(2, 4, 4, 4, TMO + 1, 1'b0, 40'd0, -1, 0);
    s_hold = cur + 2;
    go(2, 5, 5, 5, 5, 1'b0, 40'd0, -1, 0);
    for (int c = s_hold; c <= cur + 4; c++) drv_start[c] = 1'b1;
    go(0, 5, 5, 5, 5, 1'b0, 40'd0, -1, 0);
    go(3, 4, 4, 8, 4, 1'b0, 40'd0, 2, 3);
    go(2, 2, 3, 4, 5, 1'b0, 40'd0, -1, 0);
    go(1, 3, 3, 3, 3, 1'b0, 40'd0, 3, 0);
    for (int r = 0; r < 14; r++) begin
      int d [4];
      for (int k = 0; k < 4; k++)
        d[k] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TMO));
      go(int'($urandom_range(1, 4)), d[0], d[1], d[2], d[3], 1'b0, 40'd0, -1, 0);
    end
    n_end = cur + 4;
    fill_idle(cur, n_end - 1);

    for (int c = 0; c < n_end; c++) begin
      if (($urandom_range(0, 2) == 0)) drv_done[c] = drv_done[c] | (4'($urandom) & ~drv_mask[c]);
      if (e_busy[c] && $urandom_range(0, 3) == 0) drv_start[c] = 1'b1;
    end

    apply(0);
    running = 1'b1;
    for (int c = 1; c < n_end; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      apply(c);
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lenet_layer_scheduler.md
LENET_LAYER_SCHEDULER -- requirements
Module: lenet_layer_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 4, giving the signed width of each class score.
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum number of WAIT cycles allowed per layer; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin one inference; sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port layer_start, output, 4, one-hot single-cycle launch pulses: bit0 conv1, bit1 conv2, bit2 conv3, bit3 fully-connected.
REQ-008 SHALL have port layer_done, input, 4, per-engine completion pulses, with the same bit mapping.
REQ-009 SHALL have port cfg_layer, output, 2, index of the current layer (0..3), driving the kernel/matrix select muxes.
REQ-010 SHALL have port score_in, input, 10*DATA_W, packed signed FC scores; score k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-012 SHALL have port class_id, output, 4, winning class index; 4'hF on error.
REQ-013 SHALL have port class_score, output, DATA_W, signed score of the winning class.
REQ-014 SHALL have port error, output, 1, layer-timeout flag.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, WAIT, ARGMAX and DONE.
REQ-016 IDLE: when start=1 at an edge, SHALL set layer index k=0, clear error, and go to LAUNCH; start is ignored in all other states.
REQ-017 LAUNCH: SHALL assert layer_start[k] for exactly this cycle, then go to WAIT with the timeout counter at 0.
REQ-018 WAIT: on layer_done[k]=1, SHALL advance — k<3: k++ and go to LAUNCH; k=3: capture score_in into internal registers and go to ARGMAX.
REQ-019 WAIT: SHALL ignore layer_done bits other than bit k.
REQ-020 SHALL make layer_start[k+1] high exactly 1 cycle after the edge at which layer_done[k] was sampled.
REQ-021 WAIT: SHALL increment the counter on each cycle without done; if counter==TIMEOUT-1 and done is absent, set error=1, set class_id=4'hF and class_score=0, and go to DONE.
REQ-022 SHALL give layer_done priority over timeout when both occur in the same cycle.
REQ-023 ARGMAX: SHALL scan the captured scores sequentially, index 0..9, one per cycle (10 cycles), using a signed compare.
REQ-024 ARGMAX: SHALL replace the best score only on strictly greater, so ties resolve to the lowest index.
REQ-025 SHALL use captured scores only; changes on score_in after capture do not affect the result.
REQ-026 ARGMAX: SHALL write class_id and class_score at the end of the scan, then go to DONE.
REQ-027 DONE: SHALL assert done=1 for this cycle only, then go to IDLE.
REQ-028 SHALL hold class_id, class_score and error from DONE until the next accepted start.
REQ-029 SHALL drive cfg_layer=k during LAUNCH and WAIT, hold it at 3 during ARGMAX and DONE, and drive 0 in IDLE.
REQ-030 Latency: start sampled at edge t gives layer_start[0] in cycle t+1; FC done sampled at edge d gives done in cycle d+11.

Reset
REQ-031 When reset=1 at an edge, SHALL go to IDLE, with k=0, counter=0, and these outputs: busy=0, layer_start=0, cfg_layer=0, done=0, class_id=0, class_score=0, error=0.
REQ-032 SHALL give reset priority over start and layer_done in the same cycle.
REQ-033 SHALL abort a pending inference on reset at any point mid-operation, with no done pulse.

Verification
REQ-034 Nominal: start pulse; each engine answers layer_done 5 cycles after its layer_start; scores {1,-2,3,7,0,-8,7,2,-1,4} -> layer_start pulses 0,1,2,3 in order, one cycle each; done once; class_id=3, class_score=7, error=0.
REQ-035 Tie and negatives: all scores -8 except index 6 = -1 -> class_id=6, class_score=-1; all scores equal 5 -> class_id=0.
REQ-036 Timeout: TIMEOUT=16; conv2 never responds -> error=1, class_id=4'hF, done pulse 16 cycles after WAIT entry; no layer_start[2].
REQ-037 Stray and late inputs: layer_done[3] pulsed during conv1 WAIT -> ignored; start held high throughout the run -> a second run starts only after return to IDLE.
REQ-038 Reset mid-run: reset asserted during conv3 WAIT -> next cycle busy=0, all outputs 0, no done; a following start runs normally.
REQ-039 Score capture: score_in changed every cycle after the FC done edge -> result reflects values at the capture edge only.
